// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: FSM state encoding,
// default entry-field widths and reset constants.
package wb_pkg;

    // Skid-buffer occupancy / lifecycle states
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ONE    = 2'd1,
        ST_TWO    = 2'd2,
        ST_HALTED = 2'd3
    } wb_state_e;

    // Default entry-field widths
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_RADDR_W = 3;

    // Reset constants
    localparam int              RETIRE_W   = 32;
    localparam logic [RETIRE_W-1:0] RETIRE_RST = 32'h0000_0000;
    localparam logic            READY_RST  = 1'b1;

    // An entry provides forwarding data only if it is live, writes, and matches
    function automatic logic entry_hit(input logic valid, input logic we, input logic addr_eq);
        return valid & we & addr_eq;
    endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry in-order skid buffer for the writeback stage: occupancy FSM,
// push/pop control, HALT freeze and forwarding lookup.
// Entry 0 is always the head (oldest), entry 1 the tail.
module wb_skid_buf
    import wb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RADDR_W = DEF_RADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_valid,
    input  logic [DATA_W-1:0]  push_data,
    input  logic               push_we,
    input  logic [RADDR_W-1:0] push_rd,
    input  logic               push_halt,
    input  logic               rf_stall,
    output logic               in_ready,
    output logic               head_valid,
    output logic               head_we,
    output logic [RADDR_W-1:0] head_rd,
    output logic [DATA_W-1:0]  head_data,
    output logic               halted,
    input  logic [RADDR_W-1:0] fwd_raddr,
    output logic               fwd_hit,
    output logic [DATA_W-1:0]  fwd_data
);

    wb_state_e          state_r;
    wb_state_e          next_s;
    logic               ready_r;
    logic [DATA_W-1:0]  e0_data_r, e1_data_r;
    logic               e0_we_r, e1_we_r;
    logic [RADDR_W-1:0] e0_rd_r, e1_rd_r;
    logic               e0_halt_r, e1_halt_r;
    logic               head_valid_s, tail_valid_s, pop_s, halt_pop_s;
    logic               head_hit_s, tail_hit_s;
    logic               fwd_hit_s;
    logic [DATA_W-1:0]  fwd_data_s;

    assign head_valid_s = (state_r == ST_ONE) || (state_r == ST_TWO);
    assign tail_valid_s = (state_r == ST_TWO);
    assign pop_s        = head_valid_s & ~rf_stall;
    assign halt_pop_s   = pop_s & e0_halt_r;

    // Next occupancy state; a retiring HALT overrides everything else
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (push_valid) next_s = ST_ONE;
                else            next_s = ST_EMPTY;
            end
            ST_ONE: begin
                if (halt_pop_s)                 next_s = ST_HALTED;
                else if (push_valid && pop_s)   next_s = ST_ONE;
                else if (push_valid)            next_s = ST_TWO;
                else if (pop_s)                 next_s = ST_EMPTY;
                else                            next_s = ST_ONE;
            end
            ST_TWO: begin
                if (halt_pop_s)  next_s = ST_HALTED;
                else if (pop_s)  next_s = ST_ONE;
                else             next_s = ST_TWO;
            end
            ST_HALTED: next_s = ST_HALTED;
            default:   next_s = ST_EMPTY;
        endcase
    end

    // State register and registered ready, taken from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_EMPTY;
            ready_r <= READY_RST;
        end else begin
            state_r <= next_s;
            ready_r <= (next_s == ST_EMPTY) || (next_s == ST_ONE);
        end
    end

    // Entry storage: fill head when it is (or is becoming) free, else tail; shift on pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e0_data_r <= '0;
            e0_we_r   <= 1'b0;
            e0_rd_r   <= '0;
            e0_halt_r <= 1'b0;
            e1_data_r <= '0;
            e1_we_r   <= 1'b0;
            e1_rd_r   <= '0;
            e1_halt_r <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_valid) begin
                        e0_data_r <= push_data;
                        e0_we_r   <= push_we;
                        e0_rd_r   <= push_rd;
                        e0_halt_r <= push_halt;
                    end
                end
                ST_ONE: begin
                    if (push_valid && pop_s) begin
                        e0_data_r <= push_data;
                        e0_we_r   <= push_we;
                        e0_rd_r   <= push_rd;
                        e0_halt_r <= push_halt;
                    end else if (push_valid) begin
                        e1_data_r <= push_data;
                        e1_we_r   <= push_we;
                        e1_rd_r   <= push_rd;
                        e1_halt_r <= push_halt;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        e0_data_r <= e1_data_r;
                        e0_we_r   <= e1_we_r;
                        e0_rd_r   <= e1_rd_r;
                        e0_halt_r <= e1_halt_r;
                    end
                end
                default: begin
                    e0_data_r <= e0_data_r;
                end
            endcase
        end
    end

    // Forwarding lookup: the younger (tail) match wins over the head
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = '0;
        tail_hit_s = entry_hit(tail_valid_s, e1_we_r, e1_rd_r == fwd_raddr);
        head_hit_s = entry_hit(head_valid_s, e0_we_r, e0_rd_r == fwd_raddr);
        if (tail_hit_s) begin
            fwd_hit_s  = 1'b1;
            fwd_data_s = e1_data_r;
        end else if (head_hit_s) begin
            fwd_hit_s  = 1'b1;
            fwd_data_s = e0_data_r;
        end else begin
            fwd_hit_s  = 1'b0;
            fwd_data_s = '0;
        end
    end

    assign in_ready   = ready_r;
    assign head_valid = head_valid_s;
    assign head_we    = e0_we_r;
    assign head_rd    = e0_rd_r;
    assign head_data  = e0_data_r;
    assign halted     = (state_r == ST_HALTED);
    assign fwd_hit    = fwd_hit_s;
    assign fwd_data   = fwd_data_s;

endmodule

// File: rtl/wb_stage_pipe.sv
// Buffered writeback stage: result-source mux, sticky select-error flag,
// register-file write drive and optional retire counter.
// Optional feature macro: WB_RETIRE_CNT_EN (retire counter; tied to zero when undefined).
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_SRC = 8,
    parameter int SEL_W   = 3,
    parameter int RADDR_W = DEF_RADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_SRC*DATA_W-1:0] in_src,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_we,
    input  logic [RADDR_W-1:0]        in_rd,
    input  logic                      in_halt,
    input  logic                      rf_stall,
    output logic                      rf_we,
    output logic [RADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic [RADDR_W-1:0]        fwd_raddr,
    output logic                      fwd_hit,
    output logic [DATA_W-1:0]         fwd_data,
    output logic                      halted,
    output logic                      sel_err,
    output logic [31:0]               retire_cnt
);

    logic [DATA_W-1:0]  sel_data_s;
    logic               sel_bad_s;
    logic               push_s;
    logic               sel_err_r;
    logic               head_valid_s, head_we_s;
    logic [RADDR_W-1:0] head_rd_s;
    logic [DATA_W-1:0]  head_data_s;

    assign push_s = in_valid & in_ready;

    // Source mux; an out-of-range select yields zero data and flags an error
    always_comb begin
        sel_data_s = '0;
        sel_bad_s  = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (int'(in_sel) == k) begin
                sel_data_s = in_src[k*DATA_W +: DATA_W];
                sel_bad_s  = 1'b0;
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Sticky select-error flag, set only by an accepted instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_err_r <= 1'b0;
        end else if (push_s && sel_bad_s) begin
            sel_err_r <= 1'b1;
        end
    end

    wb_skid_buf #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_s),
        .push_data  (sel_data_s),
        .push_we    (in_we),
        .push_rd    (in_rd),
        .push_halt  (in_halt),
        .rf_stall   (rf_stall),
        .in_ready   (in_ready),
        .head_valid (head_valid_s),
        .head_we    (head_we_s),
        .head_rd    (head_rd_s),
        .head_data  (head_data_s),
        .halted     (halted),
        .fwd_raddr  (fwd_raddr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
    );

    assign rf_we    = head_valid_s & head_we_s & ~rf_stall;
    assign rf_waddr = head_rd_s;
    assign rf_wdata = head_data_s;
    assign sel_err  = sel_err_r;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_r;
    logic        pop_s;

    assign pop_s = head_valid_s & ~rf_stall;

    // Count every retired entry, including non-writing ones and HALT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt_r <= RETIRE_RST;
        end else if (pop_s) begin
            retire_cnt_r <= retire_cnt_r + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_r;
`else
    assign retire_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Self-checking bench for wb_stage_pipe (NUM_SRC=5 so out-of-range selects are reachable).
module tb_wb_stage_pipe;

    localparam int DW = 16;
    localparam int NS = 5;
    localparam int SW = 3;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid, in_ready, in_we, in_halt, rf_stall;
    logic [NS*DW-1:0] in_src;
    logic [SW-1:0] in_sel;
    logic [AW-1:0] in_rd, rf_waddr, fwd_raddr;
    logic rf_we, fwd_hit, halted, sel_err;
    logic [DW-1:0] rf_wdata, fwd_data;
    logic [31:0] retire_cnt;

    int errors = 0;
    int checks = 0;

    wb_stage_pipe #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .RADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src),
        .in_sel(in_sel), .in_we(in_we), .in_rd(in_rd), .in_halt(in_halt), .rf_stall(rf_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_raddr(fwd_raddr),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .halted(halted), .sel_err(sel_err),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: an in-order queue of pending instructions plus sticky flags
    typedef struct packed {
        logic [DW-1:0] data;
        logic          we;
        logic [AW-1:0] rd;
        logic          halt;
    } ent_t;

    ent_t        q[$];
    bit          m_halted, m_sel_err, m_ready;
    logic [31:0] m_cnt;
    logic [DW-1:0] src_arr [NS];

    task automatic pack_src();
        for (int k = 0; k < NS; k++) in_src[k*DW +: DW] = src_arr[k];
    endtask

    function automatic logic [DW-1:0] pick(input logic [SW-1:0] s);
        if (int'(s) < NS) return src_arr[int'(s)];
        return '0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_halted = 0; m_sel_err = 0; m_ready = 1; m_cnt = 32'd0;
    endtask

    // One clock edge of the model, using the inputs currently applied
    task automatic model_edge();
        bit acc, pop;
        ent_t e;
        acc = in_valid && m_ready;
        pop = (q.size() > 0) && !rf_stall && !m_halted;
        if (acc && int'(in_sel) >= NS) m_sel_err = 1;
        if (pop) begin
            m_cnt = m_cnt + 32'd1;
            if (q[0].halt) begin
                m_halted = 1;
                q.delete();
            end else begin
                void'(q.pop_front());
            end
        end
        if (acc && !m_halted) begin
            e.data = pick(in_sel); e.we = in_we; e.rd = in_rd; e.halt = in_halt;
            q.push_back(e);
        end
        m_ready = !m_halted && (q.size() < 2);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_we = 0; in_halt = 0; rf_stall = 0;
        in_sel = '0; in_rd = '0; fwd_raddr = '0;
        for (int k = 0; k < NS; k++) src_arr[k] = DW'($urandom);
        pack_src();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst = 0;
        model_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
        checks++; if (rf_waddr !== 3'd0) begin errors++; $display("FAIL reset_waddr got=%h exp=0", rf_waddr); end
        checks++; if (rf_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0) begin errors++; $display("FAIL reset_fwd got=%b/%h exp=0/0", fwd_hit, fwd_data); end
        checks++; if (halted !== 1'b0 || sel_err !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b/%b exp=0/0", halted, sel_err); end
        checks++; if (retire_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", retire_cnt); end
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic test_single_op();
        do_reset();
        src_arr[1] = 16'h1234; pack_src();
        in_valid = 1; in_sel = 3'd1; in_we = 1; in_rd = 3'd5;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_pre_we got=%b exp=0", rf_we); end
        tick();
        in_valid = 0;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd5 || rf_wdata !== 16'h1234) begin
            errors++; $display("FAIL single_write got=%b/%h/%h exp=1/5/1234", rf_we, rf_waddr, rf_wdata); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_after got=%b exp=0", rf_we); end
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] vals [3];
        do_reset();
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        rf_stall = 1; in_valid = 1; in_we = 1; in_sel = 3'd0;
        for (int i = 0; i < 3; i++) begin
            src_arr[0] = vals[i]; pack_src(); in_rd = AW'(i + 1);
            #1;
            checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL bp_stalled_we cyc=%0d got=%b exp=0", i, rf_we); end
            if (i == 2) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
            end
            tick();
        end
        in_valid = 0; rf_stall = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (rf_we !== 1'b1 || rf_waddr !== AW'(i + 1) || rf_wdata !== vals[i]) begin
                errors++; $display("FAIL bp_drain%0d got=%b/%h/%h exp=1/%h/%h", i, rf_we, rf_waddr, rf_wdata, i + 1, vals[i]); end
            tick();
        end
        checks++; if (rf_we !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_empty got=%b/%b exp=0/1", rf_we, in_ready); end
    endtask

    task automatic test_forwarding();
        do_reset();
        rf_stall = 1; in_valid = 1; in_we = 1; in_sel = 3'd2; in_rd = 3'd2;
        src_arr[2] = 16'hAAAA; pack_src(); tick();
        src_arr[2] = 16'hBBBB; pack_src(); tick();
        in_valid = 0; fwd_raddr = 3'd2;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'hBBBB) begin errors++; $display("FAIL fwd_tail got=%b/%h exp=1/bbbb", fwd_hit, fwd_data); end
        fwd_raddr = 3'd3;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0) begin errors++; $display("FAIL fwd_miss got=%b/%h exp=0/0", fwd_hit, fwd_data); end
        rf_stall = 0; fwd_raddr = 3'd2;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_wdata !== 16'hAAAA) begin errors++; $display("FAIL fwd_pop_head got=%b/%h exp=1/aaaa", rf_we, rf_wdata); end
        tick();
        rf_stall = 1;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'hBBBB) begin errors++; $display("FAIL fwd_head got=%b/%h exp=1/bbbb", fwd_hit, fwd_data); end
        rf_stall = 0; tick(); tick();
    endtask

    task automatic test_halt();
        int wrote_b;
        do_reset();
        in_valid = 1; in_sel = 3'd3;
        src_arr[3] = 16'hA0A0; pack_src(); in_we = 1; in_rd = 3'd3; in_halt = 0; tick();
        in_we = 0; in_halt = 1; in_rd = 3'd0;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 16'hA0A0) begin
            errors++; $display("FAIL halt_a_write got=%b/%h/%h exp=1/3/a0a0", rf_we, rf_waddr, rf_wdata); end
        tick();
        src_arr[3] = 16'hB0B0; pack_src(); in_we = 1; in_halt = 0; in_rd = 3'd4;
        wrote_b = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (rf_we === 1'b1) wrote_b++;
            tick();
        end
        checks++; if (wrote_b !== 0) begin errors++; $display("FAIL halt_b_written got=%0d exp=0", wrote_b); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got=%b exp=1", halted); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_ready got=%b exp=0", in_ready); end
        in_valid = 0;
    endtask

    task automatic test_bad_select();
        do_reset();
        for (int k = 0; k < NS; k++) src_arr[k] = 16'h8000 | DW'(k + 1);
        pack_src();
        in_valid = 1; in_we = 1;
        in_sel = 3'd6; in_rd = 3'd1; tick();
        in_sel = 3'd5; in_rd = 3'd2;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_wdata !== 16'h0) begin errors++; $display("FAIL badsel6_data got=%b/%h exp=1/0", rf_we, rf_wdata); end
        checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL badsel_err got=%b exp=1", sel_err); end
        tick();
        in_sel = 3'd4; in_rd = 3'd3;
        #1;
        checks++; if (rf_wdata !== 16'h0) begin errors++; $display("FAIL badsel5_data got=%h exp=0", rf_wdata); end
        tick();
        in_valid = 0;
        #1;
        checks++; if (rf_wdata !== 16'h8005 || sel_err !== 1'b1) begin
            errors++; $display("FAIL badsel_sticky got=%h/%b exp=8005/1", rf_wdata, sel_err); end
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        rf_stall = 1; in_valid = 1; in_we = 1; in_sel = 3'd0; in_rd = 3'd6;
        src_arr[0] = 16'hC0DE; pack_src(); tick();
        in_sel = 3'd7; tick();
        in_valid = 0; fwd_raddr = 3'd6;
        #1;
        checks++; if (in_ready !== 1'b0 || sel_err !== 1'b1) begin errors++; $display("FAIL mid_pre got=%b/%b exp=0/1", in_ready, sel_err); end
        #2 rst = 0;
        model_reset();
        #1;
        checks++; if (in_ready !== 1'b1 || rf_we !== 1'b0 || rf_waddr !== 3'd0 || rf_wdata !== 16'h0) begin
            errors++; $display("FAIL mid_rst_rf got=%b/%b/%h/%h exp=1/0/0/0", in_ready, rf_we, rf_waddr, rf_wdata); end
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0 || halted !== 1'b0 || sel_err !== 1'b0 || retire_cnt !== 32'h0) begin
            errors++; $display("FAIL mid_rst_misc got=%b/%h/%b/%b/%0d exp=0/0/0/0/0", fwd_hit, fwd_data, halted, sel_err, retire_cnt); end
        rf_stall = 0;
        @(posedge clk); #1;
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_after cyc=%0d got=%b exp=0", i, rf_we); end
            tick();
        end
    endtask

    task automatic test_retire_cnt();
        logic [31:0] exp_cnt;
        do_reset();
        in_valid = 1; in_sel = 3'd1;
        for (int i = 0; i < 10; i++) begin
            in_we = 1'($urandom); in_rd = AW'($urandom);
            tick();
        end
        in_valid = 0;
        tick();
`ifdef WB_RETIRE_CNT_EN
        exp_cnt = 32'd10;
`else
        exp_cnt = 32'd0;
`endif
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL retire_cnt got=%0d exp=%0d", retire_cnt, exp_cnt); end
    endtask

    task automatic test_random();
        bit          e_we, e_hit;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data, e_fdata;
        logic [31:0] e_cnt;
        int          halt_wait;
        do_reset();
        halt_wait = 0;
        for (int c = 0; c < 600; c++) begin
            if (m_halted) halt_wait++;
            if (halt_wait > 3) begin
                do_reset();
                halt_wait = 0;
            end
            for (int k = 0; k < NS; k++) src_arr[k] = DW'($urandom);
            pack_src();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = SW'($urandom);
            in_we     = ($urandom_range(0, 4) != 0);
            in_rd     = AW'($urandom);
            in_halt   = ($urandom_range(0, 59) == 0);
            rf_stall  = ($urandom_range(0, 9) < 3);
            fwd_raddr = AW'($urandom);
            e_we   = (q.size() > 0) && q[0].we && !rf_stall && !m_halted;
            e_addr = (q.size() > 0) ? q[0].rd : '0;
            e_data = (q.size() > 0) ? q[0].data : '0;
            e_hit  = 0; e_fdata = '0;
            for (int j = q.size() - 1; j >= 0; j--) begin
                if (!e_hit && q[j].we && q[j].rd == fwd_raddr) begin
                    e_hit = 1; e_fdata = q[j].data;
                end
            end
`ifdef WB_RETIRE_CNT_EN
            e_cnt = m_cnt;
`else
            e_cnt = 32'd0;
`endif
            #1;
            checks++; if (rf_we !== e_we) begin errors++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", c, rf_we, e_we); end
            if (e_we) begin
                checks++; if (rf_waddr !== e_addr || rf_wdata !== e_data) begin
                    errors++; $display("FAIL rnd_wr cyc=%0d got=%h/%h exp=%h/%h", c, rf_waddr, rf_wdata, e_addr, e_data); end
            end
            checks++; if (fwd_hit !== e_hit || fwd_data !== e_fdata) begin
                errors++; $display("FAIL rnd_fwd cyc=%0d got=%b/%h exp=%b/%h", c, fwd_hit, fwd_data, e_hit, e_fdata); end
            checks++; if (in_ready !== m_ready || halted !== m_halted || sel_err !== m_sel_err) begin
                errors++; $display("FAIL rnd_ctl cyc=%0d got=%b/%b/%b exp=%b/%b/%b", c, in_ready, halted, sel_err, m_ready, m_halted, m_sel_err); end
            checks++; if (retire_cnt !== e_cnt) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, retire_cnt, e_cnt); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_back_pressure();
        test_forwarding();
        test_halt();
        test_bad_select();
        test_mid_reset();
        test_retire_cnt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
